// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder for a pipeline MEM stage
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] acc_count
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;
   logic [15:0]   acc_count_q;

   // Storage is never reset so contents survive a reset pulse.
   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic          enter_resp;
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic          mem_we;

   assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
   assign accept    = req_valid && req_ready;

   // Select the request touching the array this edge: the latched one leaving WAIT,
   // or the incoming one when a single-cycle latency goes straight to RESP.
   always_comb begin
      enter_resp = 1'b0;
      acc_write  = wr_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      if ((state_q == ST_WAIT) && (cnt_q == 4'd1)) begin
         enter_resp = 1'b1;
      end else if (accept && (LATENCY == 1)) begin
         enter_resp = 1'b1;
         acc_write  = req_write;
         acc_addr   = req_addr;
         acc_wdata  = req_wdata;
      end
      acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
      acc_idx = acc_addr[AW+1:2];
      mem_we  = enter_resp && acc_write && !acc_err && reset;
   end

   // Store commit happens on the edge entering RESP; erroneous stores are dropped.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

   // Control FSM with registered response outputs and handshake counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         acc_count_q <= 16'd0;
      end else begin
         if (rsp_valid_q && rsp_ready) begin
            acc_count_q <= acc_count_q + 16'd1;
         end
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         case (state_q)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                  cnt_q   <= LAT_M1;
               end else if ((state_q == ST_RESP) && rsp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q <= ST_RESP;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
         if (enter_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_write || acc_err) ? 32'd0 : mem_q[acc_idx];
         end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign acc_count = acc_count_q;

endmodule
